// File: rtl/karatsuba_recombine.sv
// Karatsuba recombination stage.
// Takes the three partial products of one W x W multiply (k1 = hi*hi,
// k2 = lo*lo, k3 = (hi+lo)*(hi+lo)) and forms
//   prod = (k1 << W) + ((k3 - k1 - k2) << W/2) + k2   (mod 2^(2W))
// over four cycles using a single shared 2W-bit adder/subtractor.
// err reports that the middle term went negative (k3 < k1 + k2).
module karatsuba_recombine #(
  parameter int unsigned W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   k1,
  input  logic [W-1:0]   k2,
  input  logic [W+1:0]   k3,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] prod,
  output logic           err
);

  localparam int unsigned H  = W / 2;
  localparam int unsigned PW = 2 * W;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SUB1 = 3'd1,
    SUB2 = 3'd2,
    ADD  = 3'd3,
    OUT  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   acc_q,   acc_d;
  logic [W+1:0]    mid_q,   mid_d;
  logic [W-1:0]    k1r_q,   k1r_d;
  logic [W-1:0]    k2r_q,   k2r_d;
  logic            err_q,   err_d;
  logic            vld_q,   vld_d;

  // Shared adder/subtractor
  logic [PW-1:0]   op_a;
  logic [PW-1:0]   op_b;
  logic            op_sub;
  logic [PW-1:0]   sum;
  logic            borrow;

  logic [PW-1:0]   mid_zext;
  logic [PW-1:0]   mid_sext_shl;

  assign mid_zext     = {{(PW-W-2){1'b0}}, mid_q};
  assign mid_sext_shl = {{(PW-W-2){mid_q[W+1]}}, mid_q} << H;

  // Operand steering for the single adder/subtractor
  always_comb begin
    op_a   = '0;
    op_b   = '0;
    op_sub = 1'b0;
    unique case (state_q)
      SUB1: begin
        op_a   = mid_zext;
        op_b   = {{W{1'b0}}, k1r_q};
        op_sub = 1'b1;
      end
      SUB2: begin
        op_a   = mid_zext;
        op_b   = {{W{1'b0}}, k2r_q};
        op_sub = 1'b1;
      end
      ADD: begin
        op_a   = acc_q;
        op_b   = mid_sext_shl;
        op_sub = 1'b0;
      end
      default: begin
        op_a   = '0;
        op_b   = '0;
        op_sub = 1'b0;
      end
    endcase
  end

  // Two's-complement add/subtract; carry-in supplies the +1 when subtracting
  always_comb begin
    sum = op_a + (op_sub ? ~op_b : op_b) + {{(PW-1){1'b0}}, op_sub};
  end

  // Both subtraction operands are zero-extended and below 2^(W+2), so bit
  // W+2 of the wide result is set exactly when the W+2-bit subtract borrows.
  assign borrow = sum[W+2];

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mid_d   = mid_q;
    k1r_d   = k1r_q;
    k2r_d   = k2r_q;
    err_d   = err_q;
    vld_d   = vld_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          acc_d   = {k1, k2};
          mid_d   = k3;
          k1r_d   = k1;
          k2r_d   = k2;
          err_d   = 1'b0;
          state_d = SUB1;
        end
      end
      SUB1: begin
        mid_d   = sum[W+1:0];
        err_d   = borrow;
        state_d = SUB2;
      end
      SUB2: begin
        mid_d   = sum[W+1:0];
        err_d   = err_q | borrow;
        state_d = ADD;
      end
      ADD: begin
        acc_d   = sum;
        vld_d   = 1'b1;
        state_d = OUT;
      end
      OUT: begin
        if (out_ready) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        vld_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      mid_q   <= '0;
      k1r_q   <= '0;
      k2r_q   <= '0;
      err_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mid_q   <= mid_d;
      k1r_q   <= k1r_d;
      k2r_q   <= k2r_d;
      err_q   <= err_d;
      vld_q   <= vld_d;
    end
  end

  // in_ready is forced low while reset is held, even though state is IDLE
  assign in_ready  = rst_n && (state_q == IDLE);
  assign out_valid = vld_q;
  assign prod      = acc_q;
  assign err       = err_q;

endmodule

// File: tb/tb_karatsuba_recombine.sv
// Bench for karatsuba_recombine (W = 32): directed triples, scoreboard queue
// filled at acceptance, monitor pops and compares on each output handshake.
module tb_karatsuba_recombine;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] k1;
  logic [31:0] k2;
  logic [33:0] k3;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] prod;
  logic        err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [63:0] p;
    logic        e;
  } exp_t;

  exp_t sb[$];

  karatsuba_recombine #(.W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .k1        (k1),
    .k2        (k2),
    .k3        (k3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .prod      (prod),
    .err       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got hang, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  // Reference split of a, b into Karatsuba partial products and full product
  task automatic model(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] o1, output logic [31:0] o2,
                       output logic [33:0] o3, output logic [63:0] p);
    longint unsigned ah, al, bh, bl, t;
    ah = longint'(a[31:16]);
    al = longint'(a[15:0]);
    bh = longint'(b[31:16]);
    bl = longint'(b[15:0]);
    t  = ah * bh;          o1 = t[31:0];
    t  = al * bl;          o2 = t[31:0];
    t  = (ah + al) * (bh + bl); o3 = t[33:0];
    t  = longint'(a) * longint'(b); p = t;
  endtask

  // Present a triple at a negedge, wait (bounded) for in_ready, record
  // expectation and return just after the accepting edge; in_valid left high.
  task automatic send(input logic [31:0] a1, input logic [31:0] a2,
                      input logic [33:0] a3, input logic [63:0] ep,
                      input logic ee, output time t_acc);
    int unsigned n;
    n = 0;
    t_acc = 0;
    @(negedge clk);
    in_valid = 1'b1;
    k1 = a1;
    k2 = a2;
    k3 = a3;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready=%0b required 1 within 50 cycles", in_ready);
      in_valid = 1'b0;
    end else begin
      sb.push_back('{p: ep, e: ee});
      @(posedge clk);
      t_acc = $time;
      #1;
    end
  endtask

  task automatic drain(input string name);
    int unsigned n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: pending=%0d required 0", name, sb.size());
    end
  endtask

  // Monitor: every output handshake is checked against the scoreboard head
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: prod=0x%0h with empty scoreboard, required no output", prod);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (prod !== e.p) begin
          errors++;
          $display("FAIL prod: got 0x%016h required 0x%016h", prod, e.p);
        end
        checks++;
        if (err !== e.e) begin
          errors++;
          $display("FAIL err: got %0b required %0b", err, e.e);
        end
      end
    end
  end

  initial begin
    time t0, t1;
    time tacc[4];
    logic [31:0] m1, m2;
    logic [33:0] m3;
    logic [63:0] mp;
    logic [31:0] va[4];
    logic [31:0] vb[4];

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    k1 = '0;
    k2 = '0;
    k3 = '0;

    // Reset state
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_prod", prod, 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Basic with latency check: out_valid only after the third edge past accept
    send(32'd3, 32'd8, 34'd21, 64'h0000_0003_000A_0008, 1'b0, t0);
    in_valid = 1'b0;
    @(negedge clk); chk("lat_e0", 64'(out_valid), 64'd0);
    @(negedge clk); chk("lat_e1", 64'(out_valid), 64'd0);
    @(negedge clk); chk("lat_e2", 64'(out_valid), 64'd0);
    @(negedge clk); chk("lat_e3", 64'(out_valid), 64'd1);
    chk("out_in_ready", 64'(in_ready), 64'd0);
    drain("basic");

    // Maximum operands: a = b = 0xFFFFFFFF
    send(32'hFFFE_0001, 32'hFFFE_0001, 34'h3_FFF8_0004, 64'hFFFF_FFFE_0000_0001, 1'b0, t0);
    in_valid = 1'b0;
    drain("max");

    // Underflow: middle term is -6
    send(32'd5, 32'd5, 34'd4, 64'h0000_0004_FFFA_0005, 1'b1, t0);
    in_valid = 1'b0;
    drain("underflow");

    // Backpressure: output held for 10 cycles while in_valid pulses are ignored
    @(posedge clk);
    #1 out_ready = 1'b0;
    send(32'd5, 32'd5, 34'd4, 64'h0000_0004_FFFA_0005, 1'b1, t0);
    in_valid = 1'b0;
    begin
      int unsigned n;
      n = 0;
      while (!out_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = i[0];
      k1 = 32'hDEAD_0000 + 32'(i);
      k2 = 32'h1234_5678;
      k3 = 34'h0_0000_0001;
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
      chk("bp_hold_prod", prod, 64'h0000_0004_FFFA_0005);
      chk("bp_hold_err", 64'(err), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("bp_release_in_ready", 64'(in_ready), 64'd1);
    chk("bp_release_out_valid", 64'(out_valid), 64'd0);
    drain("backpressure");

    // Back-to-back: in_valid and out_ready held high, II must be 5 cycles
    va[0] = 32'h1234_5678; vb[0] = 32'h9ABC_DEF0;
    va[1] = 32'hFFFF_0001; vb[1] = 32'h0001_FFFF;
    va[2] = 32'h8000_0000; vb[2] = 32'hFFFF_FFFF;
    va[3] = 32'h0F0F_F0F0; vb[3] = 32'hCAFE_BABE;
    for (int i = 0; i < 4; i++) begin
      model(va[i], vb[i], m1, m2, m3, mp);
      send(m1, m2, m3, mp, 1'b0, tacc[i]);
    end
    in_valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      chk("b2b_interval", 64'(tacc[i] - tacc[i-1]), 64'd50);
    end
    drain("b2b");

    // Reset while in SUB2 aborts the operation
    send(32'd3, 32'd8, 34'd21, 64'h0000_0003_000A_0008, 1'b0, t0);
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    void'(sb.pop_back());
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_prod", prod, 64'd0);
    chk("abort_err", 64'(err), 64'd0);
    chk("abort_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    t1 = $time;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_no_output", 64'(out_valid), 64'd0);
    end
    send(32'd3, 32'd8, 34'd21, 64'h0000_0003_000A_0008, 1'b0, t0);
    in_valid = 1'b0;
    drain("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
